// File: rtl/ctrl_pkg.sv
// Pipeline control package: opcodes, ALU/immediate/result-path encodings
// and the Decode-to-Execute control bundle shared by decoder and pipeline.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_AND  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_func_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_fmt_e;

  typedef enum logic [1:0] {
    EX_ALU = 2'b00,
    EX_MEM = 2'b01,
    EX_PC4 = 2'b10,
    EX_IMM = 2'b11
  } expath_e;

  typedef struct packed {
    logic      valid;
    logic      reg_we;
    logic      mem_write;
    logic      branch;
    logic      jump;
    logic      jalr;
    logic      illegal;
    logic      op_a_src;
    logic      op_b_src;
    expath_e   expath;
    alu_func_e alu_func;
    logic [2:0] funct3;
  } ctrl_bundle_t;

  // funct7b5 picks SUB only for register ops (ADDI has no SUB form),
  // but picks SRA for both register and immediate shifts.
  function automatic alu_func_e alu_decode(
    input logic [2:0] f3,
    input logic       alt,
    input logic       is_r
  );
    alu_func_e f;
    case (f3)
      3'b000:  f = (alt && is_r) ? ALU_SUB : ALU_ADD;
      3'b001:  f = ALU_SLL;
      3'b010:  f = ALU_SLT;
      3'b011:  f = ALU_SLTU;
      3'b100:  f = ALU_XOR;
      3'b101:  f = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f = ALU_OR;
      default: f = ALU_AND;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/pipe_control_decoder.sv
// Combinational instruction decoder (instr_decoder): op/funct3/funct7b5 in,
// control bundle and immediate format out; unsupported encodings -> illegal.
module instr_decoder
  import ctrl_pkg::*;
#(
  parameter bit EN_SHIFT = 1'b1
) (
  input  logic [6:0]   op,
  input  logic [2:0]   funct3,
  input  logic         funct7b5,
  output ctrl_bundle_t ctrl,
  output imm_fmt_e     imm_fmt
);

  logic ill;
  logic shift;

  always_comb begin
    ctrl    = '0;
    imm_fmt = IMM_I;
    ill     = 1'b0;
    shift   = (funct3[1:0] == 2'b01);
    unique case (1'b1)
      op == OP_R: begin
        ctrl.reg_we   = 1'b1;
        ctrl.alu_func = alu_decode(funct3, funct7b5, 1'b1);
        ill           = shift && !EN_SHIFT;
      end
      op == OP_I: begin
        ctrl.reg_we   = 1'b1;
        ctrl.op_b_src = 1'b1;
        ctrl.alu_func = alu_decode(funct3, funct7b5, 1'b0);
        ill           = shift && !EN_SHIFT;
      end
      op == OP_LOAD: begin
        ctrl.reg_we   = 1'b1;
        ctrl.op_b_src = 1'b1;
        ctrl.expath   = EX_MEM;
      end
      op == OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.op_b_src  = 1'b1;
        imm_fmt        = IMM_S;
      end
      op == OP_BRANCH: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_func = ALU_SUB;
        ctrl.funct3   = funct3;
        imm_fmt       = IMM_B;
        ill           = (funct3[2:1] == 2'b01);
      end
      op == OP_JAL: begin
        ctrl.reg_we = 1'b1;
        ctrl.jump   = 1'b1;
        ctrl.expath = EX_PC4;
        imm_fmt     = IMM_J;
      end
      op == OP_JALR: begin
        ctrl.reg_we   = 1'b1;
        ctrl.jump     = 1'b1;
        ctrl.jalr     = 1'b1;
        ctrl.op_b_src = 1'b1;
        ctrl.expath   = EX_PC4;
      end
      op == OP_LUI: begin
        ctrl.reg_we = 1'b1;
        ctrl.expath = EX_IMM;
        imm_fmt     = IMM_U;
      end
      op == OP_AUIPC: begin
        ctrl.reg_we   = 1'b1;
        ctrl.op_a_src = 1'b1;
        ctrl.op_b_src = 1'b1;
        imm_fmt       = IMM_U;
      end
      default: ill = 1'b1;
    endcase
    ctrl.valid = !ill;
    // An illegal encoding carries nothing but its illegal flag.
    if (ill) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      imm_fmt      = IMM_I;
    end
  end

endmodule

// File: rtl/pipe_control.sv
// Pipeline control: Decode->Execute->Writeback control registers with
// stall/flush handling and Execute-stage branch resolution.
module pipe_control
  import ctrl_pkg::*;
#(
  parameter int ALUF_W   = 4,
  parameter bit EN_SHIFT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              StallD,
  input  logic              FlushE,
  input  logic              zero,
  input  logic              negative,
  input  logic              carry,
  output logic [2:0]        ImmFormatD,
  output logic              RegWE_E,
  output logic              RegWE_W,
  output logic              OpBSrcE,
  output logic              OpASrcE,
  output logic [1:0]        ExPathE,
  output logic [ALUF_W-1:0] ALUFuncE,
  output logic              PCSrcE,
  output logic              JALRE,
  output logic              MemWriteE,
  output logic              IllegalE
);

  ctrl_bundle_t dec;
  ctrl_bundle_t e_q;
  imm_fmt_e     imm_fmt;
  logic         regwe_w_q;
  logic         cond;

  instr_decoder #(
    .EN_SHIFT(EN_SHIFT)
  ) u_dec (
    .op      (op),
    .funct3  (funct3),
    .funct7b5(funct7b5),
    .ctrl    (dec),
    .imm_fmt (imm_fmt)
  );

  always_comb begin
    cond = 1'b0;
    case (e_q.funct3)
      3'b000:  cond = zero;
      3'b001:  cond = !zero;
      3'b100:  cond = negative;
      3'b101:  cond = !negative;
      3'b110:  cond = !carry;
      3'b111:  cond = carry;
      default: cond = 1'b0;
    endcase
  end

  assign PCSrcE = e_q.valid & (e_q.jump | (e_q.branch & cond));

  // A redirect squashes the wrong-path instruction behind it, and a bubble
  // beats a stall. During a stall the illegal flag drops so it only pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q       <= '0;
      regwe_w_q <= 1'b0;
    end else begin
      regwe_w_q <= e_q.reg_we;
      if (FlushE || PCSrcE) begin
        e_q <= '0;
      end else if (StallD) begin
        e_q.illegal <= 1'b0;
      end else begin
        e_q <= dec;
      end
    end
  end

  assign ImmFormatD = imm_fmt;
  assign RegWE_E    = e_q.reg_we;
  assign RegWE_W    = regwe_w_q;
  assign OpBSrcE    = e_q.op_b_src;
  assign OpASrcE    = e_q.op_a_src;
  assign ExPathE    = e_q.expath;
  assign ALUFuncE   = ALUF_W'(e_q.alu_func);
  assign JALRE      = e_q.jalr;
  assign MemWriteE  = e_q.mem_write;
  assign IllegalE   = e_q.illegal;

endmodule
